// File: rtl/irq_arbiter.sv
// irq_arbiter: APB-mapped 8-source priority interrupt arbiter with claim/complete handshake.
module irq_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h20001000
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  input  logic [7:0]            irq_src,
  output logic                  cpu_interrupt
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [7:0] pending, enable, active, irq_prev, rise;
  logic [7:0] claim_mask, w1c_mask, cmp_mask;
  logic [7:0][2:0] prio;
  logic [2:0] threshold, idx, best, sel;
  logic found, hit, acc_wr, acc_rd;
  logic [31:0] prio_word, rd_word;
  logic [ADDR_WIDTH-1:0] off;
  logic [3:0] cid;
  logic unused_bits;
  assign perr = 1'b0;
  assign unused_bits = ^{pstb, pdata};
  assign off = paddr - BASE_ADDR;
  assign hit = off < ADDR_WIDTH'(24) && off[1:0] == 2'b00;
  assign sel = off[4:2];
  assign acc_wr = state == ACCESS && pwrite && hit;
  assign acc_rd = state == ACCESS && !pwrite && hit;
  assign rise = irq_src & ~irq_prev;
  assign cid = pdata[3:0];
  // Strict '>' on priority keeps the lowest index on ties.
  always_comb begin
    found = 1'b0;
    idx = '0;
    best = '0;
    prio_word = '0;
    for (int i = 0; i < 8; i++) begin
      prio_word[4*i +: 3] = prio[i];
      if (pending[i] && enable[i] && !active[i] && prio[i] > threshold && (!found || prio[i] > best)) begin
        found = 1'b1;
        idx = 3'(i);
        best = prio[i];
      end
    end
  end
  assign claim_mask = acc_rd && sel == 3'd4 && found ? 8'h01 << idx : 8'h00;
  assign w1c_mask = acc_wr && sel == 3'd0 ? pdata[7:0] : 8'h00;
  assign cmp_mask = acc_wr && sel == 3'd4 && cid != 4'd0 && cid <= 4'd8 ? 8'h01 << (cid - 4'd1) : 8'h00;
  assign rd_word = sel == 3'd0 ? {24'h0, pending} :
                   sel == 3'd1 ? {24'h0, enable} :
                   sel == 3'd2 ? prio_word :
                   sel == 3'd3 ? {29'h0, threshold} :
                   sel == 3'd4 ? {28'h0, found ? 4'(idx) + 4'd1 : 4'd0} :
                   {24'h0, active};
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      pready <= 1'b0;
      prdata <= '0;
      cpu_interrupt <= 1'b0;
      pending <= '0;
      enable <= '0;
      active <= '0;
      irq_prev <= '0;
      prio <= '0;
      threshold <= '0;
    end else begin
      irq_prev <= irq_src;
      pending <= (pending & ~(w1c_mask | claim_mask)) | rise;
      active <= (active | claim_mask) & ~cmp_mask;
      cpu_interrupt <= found;
      state <= state == IDLE ? (psel && penable ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
      pready <= state == ACCESS;
      if (state == ACCESS && !pwrite)
        prdata <= hit ? DATA_WIDTH'(rd_word) : '0;
      if (acc_wr && sel == 3'd1)
        enable <= pdata[7:0];
      if (acc_wr && sel == 3'd2)
        for (int i = 0; i < 8; i++) prio[i] <= pdata[4*i +: 3];
      if (acc_wr && sel == 3'd3)
        threshold <= pdata[2:0];
    end
  end
endmodule
